// File: rtl/imm_pkg.sv
// Shared definitions for the imm_seq immediate-generation pipeline:
// format codes, RV32 base opcodes and the opcode-to-format classifier.
package imm_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Any encoding outside the table (including compressed, bits[1:0] != 11) is illegal.
  function automatic fmt_e decode_fmt(input logic [6:0] opcode);
    fmt_e fmt;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                            fmt = FMT_S;
      OP_BRANCH:                           fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    fmt = FMT_U;
      OP_JAL:                              fmt = FMT_J;
      OP_REG:                              fmt = FMT_R;
      default:                             fmt = FMT_ILL;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/s_imm_join.sv
// Joins the split store-immediate fields {funct7, rd} into one 12-bit value.
// Branch immediates reuse the same bit positions, so the top shares this join.
module s_imm_join (
  input  logic [6:0]  i_hi7,
  input  logic [4:0]  i_lo5,
  output logic [11:0] o_join
);

  assign o_join = {i_hi7, i_lo5};

endmodule

// File: rtl/imm_seq.sv
// Two-stage immediate generator: S1 holds the instruction, S2 holds the
// decoded format and sign-extended immediate. Optional IMM_ILLEGAL_CNT_EN adds ill_count.
module imm_seq
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef IMM_ILLEGAL_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
`ifdef IMM_ILLEGAL_CNT_EN
  ,
  output logic [CNT_W-1:0] ill_count
`endif
);

  logic            r_s1_valid;
  logic [31:0]     r_s1_instr;
  logic            r_s2_valid;
  logic [XLEN-1:0] r_imm;
  fmt_e            r_fmt;
  logic            r_illegal;

  logic            w_s1_ready;
  logic            w_s2_ready;
  logic            w_accept;
  logic            w_advance;
  logic [11:0]     w_s_field;
  fmt_e            w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;

  // A stage may load when it is empty or its current content leaves this edge.
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_s1_ready && !flush;
  assign w_accept   = in_valid && in_ready;
  assign w_advance  = r_s1_valid && w_s2_ready && !flush;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_instr <= '0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_s1_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_instr <= in_instr;
      end
    end
  end

  s_imm_join u_s_join (
    .i_hi7  (r_s1_instr[31:25]),
    .i_lo5  (r_s1_instr[11:7]),
    .o_join (w_s_field)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_fmt   = decode_fmt(r_s1_instr[6:0]);
    w_imm32 = '0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{r_s1_instr[31]}}, r_s1_instr[31:20]};
      FMT_S: w_imm32 = {{20{w_s_field[11]}}, w_s_field};
      FMT_B: w_imm32 = {{19{w_s_field[11]}}, w_s_field[11], w_s_field[0],
                        w_s_field[10:1], 1'b0};
      FMT_U: w_imm32 = {r_s1_instr[31:12], 12'h000};
      FMT_J: w_imm32 = {{11{r_s1_instr[31]}}, r_s1_instr[31], r_s1_instr[19:12],
                        r_s1_instr[20], r_s1_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Signed cast widens by replicating bit 31 up to XLEN.
  assign w_imm = XLEN'(signed'(w_imm32));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_imm      <= '0;
      r_fmt      <= FMT_R;
      r_illegal  <= 1'b0;
    end else begin
      if (flush) begin
        r_s2_valid <= 1'b0;
      end else if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_advance) begin
        r_imm     <= w_imm;
        r_fmt     <= w_fmt;
        r_illegal <= (w_fmt == FMT_ILL);
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_imm     = r_imm;
  assign out_fmt     = r_fmt;
  assign out_illegal = r_illegal;

`ifdef IMM_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] r_ill_cnt;

  // Counts delivered illegal results only; flush does not touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ill_cnt <= '0;
    end else if (r_s2_valid && out_ready && r_illegal && (r_ill_cnt != '1)) begin
      r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign ill_count = r_ill_cnt;
`endif

endmodule

// File: tb/tb_imm_seq.sv
// Directed self-checking bench for imm_seq with hand-computed expected values.
// Build with IMM_ILLEGAL_CNT_EN defined to also exercise ill_count.
module tb_imm_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
`ifdef IMM_ILLEGAL_CNT_EN
  logic [15:0] ill_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_seq #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal)
`ifdef IMM_ILLEGAL_CNT_EN
    ,
    .ill_count   (ill_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] fmt, input logic [31:0] imm,
                           input logic ill);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_fmt"}, 64'(out_fmt), 64'(fmt));
    check({tag, "_imm"}, 64'(out_imm), 64'(imm));
    check({tag, "_ill"}, 64'(out_illegal), 64'(ill));
  endtask

  // Sends one instruction with no backpressure, waits (bounded) for the result.
  task automatic run_one(input string tag, input logic [31:0] instr, input logic [2:0] fmt,
                         input logic [31:0] imm, input logic ill);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = instr;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd2);
    check_out(tag, fmt, imm, ill);
    tick();
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{32'h002081B3, 3'd0, 32'h00000000, 1'b0};  // add   (R)
    vecs[1] = '{32'h00500093, 3'd1, 32'h00000005, 1'b0};  // addi +5
    vecs[2] = '{32'h80012083, 3'd1, 32'hFFFFF800, 1'b0};  // lw -2048
    vecs[3] = '{32'h000080E7, 3'd1, 32'h00000000, 1'b0};  // jalr
    vecs[4] = '{32'h00512423, 3'd2, 32'h00000008, 1'b0};  // sw +8
    vecs[5] = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0};  // beq -4
    vecs[6] = '{32'h00001297, 3'd4, 32'h00001000, 1'b0};  // auipc
    vecs[7] = '{32'h00000011, 3'd7, 32'h00000000, 1'b1};  // bits[1:0]=01

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_fmt", 64'(out_fmt), 64'd0);
    check("rst_out_ill", 64'(out_illegal), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef IMM_ILLEGAL_CNT_EN
    check("rst_ill_count", 64'(ill_count), 64'd0);
`endif

    run_one("sw_m4", 32'hFE512E23, 3'd2, 32'hFFFFFFFC, 1'b0);

    // Back-to-back stream, one result per cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    tick();
    in_instr = 32'h123450B7;
    tick();
    check_out("b2b_0", 3'd1, 32'hFFFFFFFF, 1'b0);
    in_instr = 32'hFF9FF06F;
    tick();
    check_out("b2b_1", 3'd4, 32'h12345000, 1'b0);
    in_valid = 1'b0;
    tick();
    check_out("b2b_2", 3'd5, 32'hFFFFFFF8, 1'b0);
    tick();
    check("b2b_end", 64'(out_valid), 64'd0);

    run_one("ill_zero", 32'h00000000, 3'd7, 32'h00000000, 1'b1);
`ifdef IMM_ILLEGAL_CNT_EN
    check("ill_count_1", 64'(ill_count), 64'd1);
`endif

    foreach (vecs[i]) begin
      run_one($sformatf("vec%0d", i), vecs[i].instr, vecs[i].fmt, vecs[i].imm, vecs[i].ill);
    end
`ifdef IMM_ILLEGAL_CNT_EN
    check("ill_count_2", 64'(ill_count), 64'd2);
`endif

    // Backpressure: two accepted, third stalls, outputs hold.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFE512E23;
    tick();
    in_instr = 32'hFFF00093;
    tick();
    in_instr = 32'h123450B7;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check_out("bp_hold0", 3'd2, 32'hFFFFFFFC, 1'b0);
    repeat (3) tick();
    check("bp_in_ready_still_low", 64'(in_ready), 64'd0);
    check_out("bp_hold1", 3'd2, 32'hFFFFFFFC, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check_out("bp_out1", 3'd1, 32'hFFFFFFFF, 1'b0);
    tick();
    check_out("bp_out2", 3'd4, 32'h12345000, 1'b0);
    tick();
    check("bp_no_dup", 64'(out_valid), 64'd0);

    // Flush with both stages full; the concurrent offer must be refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFE512E23;
    tick();
    in_instr = 32'hFFF00093;
    tick();
    in_instr = 32'h123450B7;
    flush    = 1'b1;
    #1;
    check("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    tick();
    check("fl_not_accepted", 64'(out_valid), 64'd0);
    run_one("fl_after", 32'hFF9FF06F, 3'd5, 32'hFFFFFFF8, 1'b0);

    // Reset while results are pending.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    tick();
    in_instr = 32'h00500093;
    tick();
    in_valid = 1'b0;
    check("mr_pending", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_async_valid", 64'(out_valid), 64'd0);
    check("mr_async_imm", 64'(out_imm), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mr_in_ready", 64'(in_ready), 64'd1);
    check("mr_out_imm", 64'(out_imm), 64'd0);
    check("mr_out_valid", 64'(out_valid), 64'd0);
`ifdef IMM_ILLEGAL_CNT_EN
    check("mr_ill_count", 64'(ill_count), 64'd0);
`endif
    run_one("mr_after", 32'h00512423, 3'd2, 32'h00000008, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
